// File: rtl/ll2_pkg.sv
// Shared constants, word type and a reference shift helper for the LSL-by-2 unit.
package ll2_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int SHIFT_DEFAULT = 2;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  function automatic word_t lsl(word_t v, int n);
    return v << n;
  endfunction

endpackage

// File: rtl/ll2_shift_unit.sv
// Registered logical-left-shift unit: s = a << SHIFT with a valid qualifier and hold-on-stall.
// Overflow detection is built only when LL2_OVF_CHECK_EN is defined; otherwise ovf is constant 0.
module ll2_shift_unit
  import ll2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             ovf
);

  // Handshake: a transfer is accepted on a rising edge when in_valid=1 and stall=0;
  // while stall=1 the output register (out_valid, s, ovf) holds and inputs are ignored.
  logic [WIDTH-1:0] s_next;
  logic             load;

  assign s_next = {a[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
  assign load   = !stall && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      s         <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (load) s <= s_next;
    end
  end

`ifdef LL2_OVF_CHECK_EN
  logic ovf_next;
  logic ovf_q;

  // Any one among the bits pushed past the MSB means the byte offset lost significance.
  assign ovf_next = |a[WIDTH-1:WIDTH-SHIFT];

  always_ff @(posedge clk) begin
    if (reset)     ovf_q <= 1'b0;
    else if (load) ovf_q <= ovf_next;
  end

  assign ovf = ovf_q;
`else
  logic unused_top_bits;

  assign unused_top_bits = |a[WIDTH-1:WIDTH-SHIFT];
  assign ovf             = 1'b0;
`endif

endmodule

// File: tb/tb_ll2_shift_unit.sv
// Bench for ll2_shift_unit: directed vector table followed by randomized traffic against an arithmetic model.
module tb_ll2_shift_unit;
  import ll2_pkg::*;

`ifdef LL2_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic [63:0] a;
  logic        out_valid;
  logic [63:0] s;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  ll2_shift_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .stall     (stall),
    .a         (a),
    .out_valid (out_valid),
    .s         (s),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic        stl;
    logic [63:0] a;
    logic        exp_valid;
    logic [63:0] exp_s;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state (the registered outputs as the rules define them).
  logic        m_valid;
  logic [63:0] m_s;
  logic        m_ovf;

  task automatic add(string name, logic rst, logic vld, logic stl, logic [63:0] av,
                     logic ev, logic [63:0] es, logic eo);
    vec_t v;
    v.name = name; v.rst = rst; v.vld = vld; v.stl = stl; v.a = av;
    v.exp_valid = ev; v.exp_s = es; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic vld, logic stl, logic [63:0] av);
    reset = rst; in_valid = vld; stall = stl; a = av;
    @(posedge clk);
    #1;
  endtask

  // Model written from the rules: byte offset is word offset times four, truncated to 64 bits;
  // overflow is whether the word offset was at least 2^62.
  task automatic model_step(logic rst, logic vld, logic stl, logic [63:0] av);
    if (rst) begin
      m_valid = 1'b0; m_s = 64'd0; m_ovf = 1'b0;
    end else if (!stl) begin
      m_valid = vld;
      if (vld) begin
        m_s   = av * 64'd4;
        m_ovf = OVF_EN && (av >= 64'h4000_0000_0000_0000);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; a = '0;

    add("reset_0",    1, 1, 0, 64'd5, 0, 64'd0, 0);
    add("reset_1",    1, 1, 0, 64'd5, 0, 64'd0, 0);
    add("basic_1",    0, 1, 0, 64'd1, 1, 64'd4, 0);
    add("basic_2",    0, 1, 0, 64'd2, 1, 64'd8, 0);
    add("basic_4",    0, 1, 0, 64'd4, 1, 64'd16, 0);
    add("basic_8",    0, 1, 0, 64'd8, 1, 64'd32, 0);
    add("ovf_c0",     0, 1, 0, 64'hC000_0000_0000_0001, 1, 64'h4, OVF_EN);
    add("all_ones",   0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFC, OVF_EN);
    add("msb_set",    0, 1, 0, 64'h2000_0000_0000_0000, 1, 64'h8000_0000_0000_0000, 0);
    add("pre_stall",  0, 1, 0, 64'd3, 1, 64'd12, 0);
    add("stall_0",    0, 1, 1, 64'd7, 1, 64'd12, 0);
    add("stall_1",    0, 1, 1, 64'd7, 1, 64'd12, 0);
    add("stall_2",    0, 1, 1, 64'd7, 1, 64'd12, 0);
    add("unstall",    0, 1, 0, 64'd7, 1, 64'd28, 0);
    add("mid_reset",  1, 1, 0, 64'd9, 0, 64'd0, 0);
    add("post_reset", 0, 1, 0, 64'd10, 1, 64'd40, 0);
    add("zero",       0, 1, 0, 64'd0, 1, 64'd0, 0);
    add("idle",       0, 0, 0, 64'd55, 0, 64'd0, 0);
    add("stall_idle", 0, 1, 1, 64'd5, 0, 64'd0, 0);
    add("restart",    0, 1, 0, 64'd5, 1, 64'd20, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].stl, vecs[i].a);
      check({vecs[i].name, ".valid"}, {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
      check({vecs[i].name, ".s"},     s,                  vecs[i].exp_s);
      check({vecs[i].name, ".ovf"},   {63'd0, ovf},       {63'd0, vecs[i].exp_ovf});
    end

    // Randomized traffic; model starts from a clean reset.
    drive(1, 0, 0, 64'd0);
    model_step(1, 0, 0, 64'd0);
    for (int n = 0; n < 400; n++) begin
      logic        r_rst, r_vld, r_stl;
      logic [63:0] r_a;
      r_rst = ($urandom_range(0, 29) == 0);
      r_stl = ($urandom_range(0, 3) == 0);
      r_vld = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0:       r_a = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       r_a = {2'($urandom_range(0, 3)), 62'd0} | 64'($urandom_range(0, 7));
        default: r_a = {$urandom, $urandom};
      endcase
      drive(r_rst, r_vld, r_stl, r_a);
      model_step(r_rst, r_vld, r_stl, r_a);
      check("rand.valid", {63'd0, out_valid}, {63'd0, m_valid});
      check("rand.s",     s,                  m_s);
      check("rand.ovf",   {63'd0, ovf},       {63'd0, m_ovf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ll2_shift_unit.md
Name: ll2_shift_unit

Overview:
- Logical-left-shift-by-2 unit for the ARMv8 pipeline.
- Converts a 64-bit word offset (branch/PC-relative immediate) into a byte offset, S = A << 2.
- Registered, single-stage block with a valid qualifier, feeding the branch-target adder in the execute stage.

Parameters:
- WIDTH, 64, data width of a and s.
- SHIFT, 2, fixed left-shift amount; legal range 1..WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a is valid this cycle.
- stall  input  1  hold the output register; in_valid and a are ignored while high.
- a  input  WIDTH  operand (word offset).
- out_valid  output  1  s and ovf are valid.
- s  output  WIDTH  a << SHIFT, zero-filled LSBs, registered.
- ovf  output  1  any bit shifted out of the MSB end was 1, registered.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising clk with reset=1, out_valid=0, s=0, ovf=0. Reset has priority over stall and in_valid.
- Shift function:
  - s_next[WIDTH-1:SHIFT] = a[WIDTH-1-SHIFT:0].
  - s_next[SHIFT-1:0] = 0.
  - No sign extension; the operation is purely logical.
- Latency is exactly 1 cycle: a sampled at edge N appears on s after edge N.
- Update rule, at each rising edge with reset=0:
  - If stall=1: out_valid, s and ovf all hold their values.
  - If stall=0: out_valid <= in_valid.
  - If stall=0 and in_valid=1: s <= s_next and ovf <= ovf_next.
  - If stall=0 and in_valid=0: s and ovf hold their last values, but are don't-care because out_valid=0.
- Boundaries:
  - a=0 gives s=0.
  - a with a[WIDTH-1-SHIFT]=1 yields s MSB set.
  - a=all-ones yields s = all-ones with SHIFT zero LSBs.
- Back-to-back valid inputs are accepted every cycle with no bubbles.
- Reset asserted mid-stream drops the in-flight result: out_valid=0 the next cycle.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: LL2_OVF_CHECK_EN.
- Defined: ovf_next = OR of a[WIDTH-1:WIDTH-SHIFT]. This flags that the byte offset lost significant bits.
- Not defined: ovf is tied to constant 0 and no overflow logic is synthesized.
- The ports are identical in both builds.

Decomposition:
- Shared package ll2_pkg holds:
  - the WIDTH_DEFAULT=64 and SHIFT_DEFAULT=2 constants;
  - a typedef word_t = logic [WIDTH_DEFAULT-1:0].
- No sub-module is needed; the shift is combinational inside the block, followed by the output register.
- Optional helper function ll2_pkg::lsl(word_t, int) returns the shifted value for reuse by the bench model.

Test Plan:
- Reset: reset=1 for 2 cycles with in_valid=1, a=5 -> out_valid=0, s=0, ovf=0.
- Basic sequence: in_valid=1 with a=1, 2, 4, 8 on consecutive cycles -> s=4, 8, 16, 32 one cycle later each, with out_valid=1 and ovf=0.
- Overflow (macro defined): a=64'hC000_0000_0000_0001 -> s=64'h0000_0000_0000_0004, ovf=1. The same input without the macro -> ovf=0.
- Boundary: a=64'hFFFF_FFFF_FFFF_FFFF -> s=64'hFFFF_FFFF_FFFF_FFFC. Separately, a=64'h2000_0000_0000_0000 -> s=64'h8000_0000_0000_0000, ovf=0.
- Stall: after a=3 produces s=12, assert stall for 3 cycles while driving a=7 -> s stays 12 and out_valid stays 1. Release stall -> s=28 on the next cycle.
- Mid-stream reset: in_valid=1, a=9, with reset asserted on the same edge -> out_valid=0, s=0. Deassert reset with a=10 -> s=40, out_valid=1.
